filter_test_sequencer: RTL and testbench
========================================

FILTER_TEST_SEQUENCER -- requirements
Module: filter_test_sequencer

Interface
REQ-001 Parameter SIZE_DELAY, default 8: width of the delay code driven to the signal generator.
REQ-002 Parameter SIZE_FILTER_DATA, default 16: width of the filter output under measurement, signed two's complement.
REQ-003 Parameter SETTLE_CYCLES, default 64: cycles to wait after a setting change before measuring, range 1..65535.
REQ-004 Parameter MEASURE_CYCLES, default 256: cycles of the peak-capture window, range 1..65535.
REQ-005 Parameter DELAY_STEP, default 1: delay increment between scan points, at least 1.
REQ-006 Parameter DELAY_MAX, default 2**SIZE_DELAY-1: last delay code allowed in the scan.
REQ-007 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port start, input, 1 bit: single-cycle request to begin a scan; sampled only in IDLE.
REQ-010 Port abort, input, 1 bit: terminates a scan in progress.
REQ-011 Port rate_sel, input, 1 bit: rate mode to use for the scan; latched when start is accepted.
REQ-012 Port filter_data, input, SIZE_FILTER_DATA bits: selected filter output, signed.
REQ-013 Port test_overlay, output, 1 bit: overlay control driven to the signal generator.
REQ-014 Port test_rate, output, 1 bit: rate control driven to the signal generator.
REQ-015 Port test_delay, output, SIZE_DELAY bits: delay code driven to the signal generator.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.
REQ-017 Port done, output, 1 bit: one-cycle pulse when a scan completes normally.
REQ-018 Port result_valid, output, 1 bit: result available.
REQ-019 Port result_ready, input, 1 bit: consumer accepts the result.
REQ-020 Port result_delay, output, SIZE_DELAY bits: delay code of the reported point.
REQ-021 Port result_overlay, output, 1 bit: overlay setting of the reported point.
REQ-022 Port result_peak, output, SIZE_FILTER_DATA bits: signed maximum of filter_data over the window.

Function
REQ-023 The block SHALL implement the states IDLE, SETUP, SETTLE, MEASURE, REPORT and FINISH.
REQ-024 In IDLE, start=1 SHALL latch rate_sel, clear delay and overlay to 0, and go to SETUP.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 SETUP SHALL last exactly 1 cycle: drive test_delay, test_overlay and test_rate from internal registers, load the settle counter, then go to SETTLE.
REQ-027 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to MEASURE.
REQ-028 MEASURE SHALL last exactly MEASURE_CYCLES cycles; peak SHALL be preset to the most-negative value on entry and update as peak = max(peak, filter_data) (signed compare) every MEASURE cycle, including the first.
REQ-029 REPORT SHALL hold result_valid=1 with result_* stable until result_valid & result_ready, and SHALL NOT change result_* while waiting.
REQ-030 On acceptance the next point SHALL be selected by REQ-037/038; next delay = delay + DELAY_STEP, computed SIZE_DELAY+1 bits wide.
REQ-031 If next delay > DELAY_MAX or overflows SIZE_DELAY bits, the block SHALL go to FINISH, never wrapping; otherwise it SHALL go to SETUP.
REQ-032 FINISH SHALL pulse done=1 for 1 cycle, then return to IDLE.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, drop result_valid, suppress done, and leave test_* outputs at their last values; abort in IDLE has no effect.
REQ-034 If abort and result_ready are both asserted in REPORT, abort SHALL win and the result counts as not delivered.
REQ-035 filter_data SHALL be ignored outside MEASURE.

Reset
REQ-036 While reset=1, the block SHALL immediately hold state=IDLE, busy=0, done=0, result_valid=0, test_overlay=0, test_rate=0, test_delay=0, result_delay=0, result_overlay=0, result_peak=0 and all counters 0; reset mid-scan SHALL discard the scan.

Configuration
REQ-037 With FILTER_SEQ_OVERLAY_EN defined, each delay point SHALL be measured twice (overlay=0, then overlay=1), and the delay SHALL advance only after the overlay=1 result is accepted.
REQ-038 Without FILTER_SEQ_OVERLAY_EN, test_overlay and result_overlay SHALL be constant 0 and each delay point SHALL be measured once.

Verification (SETTLE_CYCLES=4, MEASURE_CYCLES=8, DELAY_STEP=4, DELAY_MAX=12, SIZE_DELAY=8)
REQ-039 start, result_ready=1, macro undefined -> 4 results with delays 0,4,8,12; 1+4+8+1 cycles per point; done pulses once; busy then falls.
REQ-040 Same run with macro defined -> 8 results ordered (0,0),(0,1),(4,0)...(12,1).
REQ-041 filter_data sequence -5,-3,7,-32768,2,7,0,-1 in the window -> result_peak=7; an all -32768 window -> result_peak=-32768.
REQ-042 result_ready held 0 for 10 cycles in REPORT -> result_valid stays 1, result_* stable, no state advance; one ready cycle -> exactly one transfer.
REQ-043 abort in MEASURE of delay 8, and separately with abort and ready both high in REPORT -> IDLE next cycle, no done, no further results; a new start rescans from delay 0.
REQ-044 DELAY_STEP=100, DELAY_MAX=255 -> delays 0,100,200, then FINISH with no wrap to 44.

Source files
------------

// File: rtl/filter_test_sequencer.sv
// Delay/overlay scan sequencer: steps a signal generator through delay codes and reports the signed
// peak of the filter output at each point. Optional build macro: FILTER_SEQ_OVERLAY_EN (two overlay passes per delay).
module filter_test_sequencer #(
   parameter int SIZE_DELAY       = 8,
   parameter int SIZE_FILTER_DATA = 16,
   parameter int SETTLE_CYCLES    = 64,
   parameter int MEASURE_CYCLES   = 256,
   parameter int DELAY_STEP       = 1,
   parameter int DELAY_MAX        = 2**SIZE_DELAY-1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        rate_sel,
   input  logic [SIZE_FILTER_DATA-1:0] filter_data,
   output logic                        test_overlay,
   output logic                        test_rate,
   output logic [SIZE_DELAY-1:0]       test_delay,
   output logic                        busy,
   output logic                        done,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic [SIZE_DELAY-1:0]       result_delay,
   output logic                        result_overlay,
   output logic [SIZE_FILTER_DATA-1:0] result_peak
);

`ifdef FILTER_SEQ_OVERLAY_EN
   localparam logic OVERLAY_EN = 1'b1;
`else
   localparam logic OVERLAY_EN = 1'b0;
`endif

   localparam logic [SIZE_DELAY:0] STEP_EXT     = (SIZE_DELAY+1)'(DELAY_STEP);
   localparam logic [SIZE_DELAY:0] MAX_EXT      = (SIZE_DELAY+1)'(DELAY_MAX);
   localparam logic [15:0]         SETTLE_LOAD  = 16'(SETTLE_CYCLES-1);
   localparam logic [15:0]         MEASURE_LOAD = 16'(MEASURE_CYCLES-1);
   localparam logic signed [SIZE_FILTER_DATA-1:0] PEAK_MIN = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SETTLE  = 3'd2,
      MEASURE = 3'd3,
      REPORT  = 3'd4,
      FINISH  = 3'd5
   } state_t;

   state_t                              state, next_state;
   logic [15:0]                         cnt;
   logic [SIZE_DELAY-1:0]               delay;
   logic                                overlay;
   logic                                rate;
   logic signed [SIZE_FILTER_DATA-1:0]  peak;
   logic signed [SIZE_FILTER_DATA-1:0]  peak_next;
   logic [SIZE_DELAY:0]                 delay_next;
   logic                                last_point;
   logic                                cnt_zero;

   // Next-state decode; abort overrides everything outside IDLE, including a simultaneous accept.
   always_comb begin
      peak_next  = ($signed(filter_data) > peak) ? $signed(filter_data) : peak;
      delay_next = {1'b0, delay} + STEP_EXT;
      last_point = delay_next[SIZE_DELAY] || (delay_next > MAX_EXT);
      cnt_zero   = (cnt == 16'd0);
      next_state = state;
      if ((state != IDLE) && abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) next_state = SETUP; else next_state = IDLE;
            SETUP:   next_state = SETTLE;
            SETTLE:  if (cnt_zero) next_state = MEASURE; else next_state = SETTLE;
            MEASURE: if (cnt_zero) next_state = REPORT; else next_state = MEASURE;
            REPORT: begin
               if (!result_ready)                next_state = REPORT;
               else if (OVERLAY_EN && !overlay) next_state = SETUP;
               else if (last_point)             next_state = FINISH;
               else                             next_state = SETUP;
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // State, status flags and scan datapath; status flags are decoded from next_state so they are registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         result_valid   <= 1'b0;
         test_overlay   <= 1'b0;
         test_rate      <= 1'b0;
         test_delay     <= {SIZE_DELAY{1'b0}};
         result_delay   <= {SIZE_DELAY{1'b0}};
         result_overlay <= 1'b0;
         result_peak    <= {SIZE_FILTER_DATA{1'b0}};
         cnt            <= 16'd0;
         delay          <= {SIZE_DELAY{1'b0}};
         overlay        <= 1'b0;
         rate           <= 1'b0;
         peak           <= {SIZE_FILTER_DATA{1'b0}};
      end else begin
         state        <= next_state;
         busy         <= (next_state != IDLE);
         done         <= (next_state == FINISH);
         result_valid <= (next_state == REPORT);
         case (state)
            IDLE: begin
               if (start) begin
                  rate    <= rate_sel;
                  delay   <= {SIZE_DELAY{1'b0}};
                  overlay <= 1'b0;
               end
            end
            SETUP: begin
               if (next_state == SETTLE) begin
                  test_delay   <= delay;
                  test_overlay <= overlay;
                  test_rate    <= rate;
                  cnt          <= SETTLE_LOAD;
               end
            end
            SETTLE: begin
               if (next_state == MEASURE) begin
                  cnt  <= MEASURE_LOAD;
                  peak <= PEAK_MIN;
               end else if (next_state == SETTLE) begin
                  cnt <= cnt - 16'd1;
               end
            end
            MEASURE: begin
               if (next_state == MEASURE) begin
                  peak <= peak_next;
                  cnt  <= cnt - 16'd1;
               end else if (next_state == REPORT) begin
                  // The last window sample is folded straight into the reported peak.
                  result_peak    <= peak_next;
                  result_delay   <= delay;
                  result_overlay <= overlay;
               end
            end
            REPORT: begin
               if ((next_state == SETUP) && OVERLAY_EN && !overlay) begin
                  overlay <= 1'b1;
               end else if (next_state == SETUP) begin
                  overlay <= 1'b0;
                  delay   <= delay_next[SIZE_DELAY-1:0];
               end
            end
            default: begin
               cnt <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Scoreboard bench for filter_test_sequencer: directed scans, stall, abort, reset and step-overflow cases.
module tb_filter_test_sequencer;
`ifdef FILTER_SEQ_OVERLAY_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int NP  = 4 * PASSES;
   localparam int PER = 14;

   typedef struct {
      int d;
      int o;
      int p;
   } exp_t;

   logic clk = 1'b0;
   logic reset, start, abort, rate_sel, result_ready;
   logic [15:0] filter_data;
   logic test_overlay, test_rate, busy, done, result_valid, result_overlay;
   logic [7:0] test_delay, result_delay;
   logic [15:0] result_peak;

   logic start2, abort2, ready2;
   logic [15:0] filter_data2;
   logic test_overlay2, test_rate2, busy2, done2, valid2, result_overlay2;
   logic [7:0] test_delay2, result_delay2;
   logic [15:0] result_peak2;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int done2_cnt = 0;
   int done_base;

   logic signed [15:0] data_tab [4][8] = '{
      '{-16'sd5, -16'sd3, 16'sd7, 16'sh8000, 16'sd2, 16'sd7, 16'sd0, -16'sd1},
      '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000},
      '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd300},
      '{16'sd1000, -16'sd2, -16'sd50, -16'sd60, -16'sd70, -16'sd80, -16'sd90, -16'sd99}
   };
   int peak_tab [4] = '{7, -32768, 300, 1000};

   filter_test_sequencer #(
      .SIZE_DELAY(8), .SIZE_FILTER_DATA(16), .SETTLE_CYCLES(4), .MEASURE_CYCLES(8),
      .DELAY_STEP(4), .DELAY_MAX(12)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .rate_sel(rate_sel),
      .filter_data(filter_data), .test_overlay(test_overlay), .test_rate(test_rate),
      .test_delay(test_delay), .busy(busy), .done(done), .result_valid(result_valid),
      .result_ready(result_ready), .result_delay(result_delay),
      .result_overlay(result_overlay), .result_peak(result_peak)
   );

   filter_test_sequencer #(
      .SIZE_DELAY(8), .SIZE_FILTER_DATA(16), .SETTLE_CYCLES(4), .MEASURE_CYCLES(8),
      .DELAY_STEP(100), .DELAY_MAX(255)
   ) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .abort(abort2), .rate_sel(1'b0),
      .filter_data(filter_data2), .test_overlay(test_overlay2), .test_rate(test_rate2),
      .test_delay(test_delay2), .busy(busy2), .done(done2), .result_valid(valid2),
      .result_ready(ready2), .result_delay(result_delay2),
      .result_overlay(result_overlay2), .result_peak(result_peak2)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Monitor: pops the scoreboard on every completed result handshake and counts done pulses.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (done2) done2_cnt++;
      if (result_valid && result_ready && !abort) begin
         if (q1.size() == 0) begin
            check("extra_result_delay", int'(result_delay), -1);
         end else begin
            e1 = q1.pop_front();
            check("res_delay", int'(result_delay), e1.d);
            check("res_overlay", int'(result_overlay), e1.o);
            check("res_peak", int'($signed(result_peak)), e1.p);
         end
      end
      if (valid2 && ready2) begin
         if (q2.size() == 0) begin
            check("extra_result2_delay", int'(result_delay2), -1);
         end else begin
            e2 = q2.pop_front();
            check("res2_delay", int'(result_delay2), e2.d);
            check("res2_overlay", int'(result_overlay2), e2.o);
            check("res2_peak", int'($signed(result_peak2)), e2.p);
         end
      end
   end

   // Full scan with ready held high; sched selects the per-point data table, otherwise constant 42.
   task automatic run_scan(input bit sched);
      int p, k;
      for (int i = 0; i < NP; i++)
         q1.push_back('{(i / PASSES) * 4, i % PASSES, sched ? peak_tab[i % 4] : 42});
      done_base = done_cnt;
      result_ready = 1'b1;
      rate_sel = 1'b1;
      start = 1'b1;
      filter_data = 16'h7fff;
      @(posedge clk); #1;
      start = 1'b0;
      rate_sel = 1'b0;
      for (int t = 1; t <= NP * PER + 1; t++) begin
         p = (t - 1) % PER;
         k = (t - 1) / PER;
         if (t <= NP * PER && p >= 5 && p <= 12)
            filter_data = sched ? data_tab[k % 4][p - 5] : 16'd42;
         else
            filter_data = 16'h7fff;
         start = (t == 20);
         if (t == 1) check("scan_busy", int'(busy), 1);
         if (t <= NP * PER && p == 3) begin
            check("scan_test_delay", int'(test_delay), (k / PASSES) * 4);
            check("scan_test_overlay", int'(test_overlay), k % PASSES);
            check("scan_test_rate", int'(test_rate), 1);
         end
         if (t == NP * PER + 1) check("scan_done", int'(done), 1);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("scan_end_busy", int'(busy), 0);
      check("scan_done_pulses", done_cnt - done_base, 1);
      check("scan_queue_left", q1.size(), 0);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; abort = 1'b0; rate_sel = 1'b0; result_ready = 1'b0;
      filter_data = 16'd0; start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1; filter_data2 = 16'hffff;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_valid", int'(result_valid), 0);
      check("rst_test_overlay", int'(test_overlay), 0);
      check("rst_test_rate", int'(test_rate), 0);
      check("rst_test_delay", int'(test_delay), 0);
      check("rst_result_delay", int'(result_delay), 0);
      check("rst_result_overlay", int'(result_overlay), 0);
      check("rst_result_peak", int'(result_peak), 0);
      @(posedge clk); #1;
      start = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset_busy", int'(busy), 0);

      run_scan(1'b1);

      // Stall in REPORT, then one-cycle accept, then abort together with ready.
      q1.push_back('{0, 0, 42});
      result_ready = 1'b0; rate_sel = 1'b0; start = 1'b1; filter_data = 16'd42;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!result_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("stall_valid_seen", int'(result_valid), 1);
      for (int i = 0; i < 10; i++) begin
         check("stall_valid", int'(result_valid), 1);
         check("stall_delay", int'(result_delay), 0);
         check("stall_peak", int'($signed(result_peak)), 42);
         check("stall_test_delay", int'(test_delay), 0);
         check("stall_test_rate", int'(test_rate), 0);
         @(posedge clk); #1;
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check("one_transfer_queue", q1.size(), 0);
      check("after_accept_valid", int'(result_valid), 0);
      n = 0;
      while (!result_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("second_valid_seen", int'(result_valid), 1);
      done_base = done_cnt;
      abort = 1'b1; result_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_rep_busy", int'(busy), 0);
      check("abort_rep_valid", int'(result_valid), 0);
      check("abort_rep_done", int'(done), 0);
      check("abort_rep_test_delay", int'(test_delay), (PASSES == 2) ? 0 : 4);
      check("abort_rep_test_overlay", int'(test_overlay), PASSES - 1);
      repeat (20) @(posedge clk);
      #1;
      check("abort_rep_no_done", done_cnt - done_base, 0);
      check("abort_rep_still_idle", int'(busy), 0);

      // Abort during MEASURE of delay 8.
      for (int i = 0; i < 2 * PASSES; i++) q1.push_back('{(i / PASSES) * 4, i % PASSES, 42});
      done_base = done_cnt;
      result_ready = 1'b1; start = 1'b1; filter_data = 16'd42;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2 * PASSES * PER + 7) @(posedge clk);
      #1;
      check("abort_meas_pre_delay", int'(test_delay), 8);
      check("abort_meas_pre_busy", int'(busy), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_meas_busy", int'(busy), 0);
      check("abort_meas_valid", int'(result_valid), 0);
      check("abort_meas_test_delay", int'(test_delay), 8);
      repeat (30) @(posedge clk);
      #1;
      check("abort_meas_no_done", done_cnt - done_base, 0);
      check("abort_meas_queue", q1.size(), 0);

      run_scan(1'b0);

      // Asynchronous reset in the middle of a scan.
      q1.push_back('{0, 0, 42});
      result_ready = 1'b1; rate_sel = 1'b1; start = 1'b1; filter_data = 16'd42;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_test_delay", int'(test_delay), 0);
      check("mid_rst_test_rate", int'(test_rate), 0);
      check("mid_rst_peak", int'(result_peak), 0);
      check("mid_rst_queue", q1.size(), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Large step must stop at 200 without wrapping.
      for (int i = 0; i < 3 * PASSES; i++) q2.push_back('{(i / PASSES) * 100, i % PASSES, -1});
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      repeat (3 * PASSES * PER + 5) @(posedge clk);
      #1;
      check("step_done_pulses", done2_cnt, 1);
      check("step_queue_left", q2.size(), 0);
      check("step_busy", int'(busy2), 0);
      check("step_last_delay", int'(test_delay2), 200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
